// File: rtl/nes_joypad_responder_pkg.sv
// Shared constants and types for the NES joypad responder.
// Optional turbo build: define NES_JOYPAD_TURBO_EN.
package nes_joy_pkg;

  localparam int NUM_BUTTONS = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // bit_cnt stops here once the whole report has been clocked out
  localparam logic [3:0] BIT_CNT_SAT  = 4'd8;
  localparam logic [3:0] BIT_CNT_LAST = 4'd7;

  typedef enum logic {
    ST_LOAD,
    ST_SHIFT
  } joy_state_e;

endpackage

// File: rtl/nes_joypad_responder_if.sv
// Pad-side bus: host strobe/clock/data plus parallel button inputs and status.
interface nes_joypad_responder_if;
  import nes_joy_pkg::*;

  logic                   joy_strobe;
  logic                   joy_clock;
  logic                   joy_data;
  logic [NUM_BUTTONS-1:0] buttons;
  logic                   turbo_a;
  logic                   turbo_b;
  logic [NUM_BUTTONS-1:0] latched;
  logic                   read_done;

  // master: host/bench side driving the pad
  modport master (
    output joy_strobe, joy_clock, buttons, turbo_a, turbo_b,
    input  joy_data, latched, read_done
  );

  // slave: the emulated pad
  modport slave (
    input  joy_strobe, joy_clock, buttons, turbo_a, turbo_b,
    output joy_data, latched, read_done
  );
endinterface

// File: rtl/nes_joypad_responder_sync_edge.sv
// Multi-flop synchronizer with a registered level and rise/fall pulses.
module joy_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // synchronizer chain plus one flop holding the previous synced level
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  =  level & ~prev_q;
  assign fall  = ~level &  prev_q;
endmodule

// File: rtl/nes_joypad_responder.sv
// Emulates the 4021 shift register inside a standard NES pad.
// Optional turbo on A/B is compiled in with NES_JOYPAD_TURBO_EN.
module nes_joypad_responder
  import nes_joy_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int SOCD_MASK    = 1,
  parameter int TURBO_PERIOD = 4
) (
  input logic                   clock,
  input logic                   reset_n,
  nes_joypad_responder_if.slave bus
);
  logic strb_level, strb_rise, strb_fall;
  logic clk_level, clk_rise, clk_fall;

  joy_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_strb_sync (
    .clock(clock), .reset_n(reset_n), .d(bus.joy_strobe),
    .level(strb_level), .rise(strb_rise), .fall(strb_fall)
  );

  joy_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clock(clock), .reset_n(reset_n), .d(bus.joy_clock),
    .level(clk_level), .rise(clk_rise), .fall(clk_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{strb_rise, clk_level, clk_fall};

  logic [NUM_BUTTONS-1:0] cond;
  logic [NUM_BUTTONS-1:0] sr_q, sr_d, latched_q, latched_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   data_q, done_q, done_d;
  joy_state_e             state;

`ifdef NES_JOYPAD_TURBO_EN
  logic [7:0] turbo_cnt_q;
  logic       turbo_phase_q;

  // turbo phase flips every TURBO_PERIOD strobe falling edges
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      turbo_cnt_q   <= '0;
      turbo_phase_q <= 1'b0;
    end else if (strb_fall) begin
      if (turbo_cnt_q == 8'(TURBO_PERIOD - 1)) begin
        turbo_cnt_q   <= '0;
        turbo_phase_q <= ~turbo_phase_q;
      end else begin
        turbo_cnt_q   <= turbo_cnt_q + 8'd1;
      end
    end
  end
`else
  logic unused_turbo;
  assign unused_turbo = ^{bus.turbo_a, bus.turbo_b, 8'(TURBO_PERIOD)};
`endif

  // button conditioning: SOCD masking, then turbo substitution
  always_comb begin
    cond = bus.buttons;
    if (SOCD_MASK != 0) begin
      if (cond[BTN_UP] && cond[BTN_DOWN]) begin
        cond[BTN_UP]   = 1'b0;
        cond[BTN_DOWN] = 1'b0;
      end
      if (cond[BTN_LEFT] && cond[BTN_RIGHT]) begin
        cond[BTN_LEFT]  = 1'b0;
        cond[BTN_RIGHT] = 1'b0;
      end
    end
`ifdef NES_JOYPAD_TURBO_EN
    if (bus.turbo_a) cond[BTN_A] = turbo_phase_q;
    if (bus.turbo_b) cond[BTN_B] = turbo_phase_q;
`endif
  end

  // The synced strobe level is the state register; the falling-edge cycle
  // still counts as LOAD so a coincident clock edge cannot shift.
  always_comb begin
    state = (strb_level || strb_fall) ? ST_LOAD : ST_SHIFT;
  end

  // next-state for shift register, bit counter, snapshot and done pulse
  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    latched_d = latched_q;
    done_d    = 1'b0;
    case (state)
      ST_LOAD: begin
        sr_d  = cond;
        cnt_d = '0;
      end
      ST_SHIFT: begin
        if (clk_rise) begin
          // fill with 1 so over-reads report "pressed" like an official pad
          sr_d = {1'b1, sr_q[NUM_BUTTONS-1:1]};
          if (cnt_q != BIT_CNT_SAT) cnt_d = cnt_q + 4'd1;
          done_d = (cnt_q == BIT_CNT_LAST);
        end
      end
      default: ;
    endcase
    if (strb_fall) latched_d = cond;
  end

  // register everything; joy_data is the inverted next LSB
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      latched_q <= '0;
      data_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      latched_q <= latched_d;
      data_q    <= ~sr_d[0];
      done_q    <= done_d;
    end
  end

  assign bus.joy_data  = data_q;
  assign bus.latched   = latched_q;
  assign bus.read_done = done_q;
endmodule

// File: tb/tb_nes_joypad_responder.sv
// Bench: two pads (SOCD on / SOCD off, different sync depths) driven by one host.
module tb_nes_joypad_responder;
  localparam int TP = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic strb = 1'b0, jclk = 1'b0, ta = 1'b0, tbv = 1'b0;
  logic [7:0] btn = 8'h00;

  always #5 clock = ~clock;

  nes_joypad_responder_if if0 ();
  nes_joypad_responder_if if1 ();

  assign if0.joy_strobe = strb;  assign if1.joy_strobe = strb;
  assign if0.joy_clock  = jclk;  assign if1.joy_clock  = jclk;
  assign if0.buttons    = btn;   assign if1.buttons    = btn;
  assign if0.turbo_a    = ta;    assign if1.turbo_a    = ta;
  assign if0.turbo_b    = tbv;   assign if1.turbo_b    = tbv;

  nes_joypad_responder #(.SYNC_STAGES(2), .SOCD_MASK(1), .TURBO_PERIOD(TP)) dut0 (
    .clock(clock), .reset_n(reset_n), .bus(if0)
  );
  nes_joypad_responder #(.SYNC_STAGES(3), .SOCD_MASK(0), .TURBO_PERIOD(TP)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(if1)
  );

  int checks = 0, errors = 0;
  int done0 = 0, done1 = 0, exp_done = 0;
  int n_strobes = 0, bits_read = 0;
  logic [7:0] exp_c0, exp_c1;

  // count read_done pulses, one per high cycle
  always @(posedge clock) begin
    if (if0.read_done) done0 <= done0 + 1;
    if (if1.read_done) done1 <= done1 + 1;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // report the pad should present for buttons b at the next strobe fall
  function automatic logic [7:0] model(input logic [7:0] b, input bit socd);
    logic [7:0] c;
    c = b;
    if (socd && b[4] && b[5]) c[5:4] = 2'b00;
    if (socd && b[6] && b[7]) c[7:6] = 2'b00;
`ifdef NES_JOYPAD_TURBO_EN
    if (ta)  c[0] = ((n_strobes / TP) % 2) == 1;
    if (tbv) c[1] = ((n_strobes / TP) % 2) == 1;
`endif
    return c;
  endfunction

  // host sees ~bit for the first eight reads, then constant 0
  function automatic logic exp_bit(input logic [7:0] c, input int idx);
    return (idx < 8) ? ~c[idx] : 1'b0;
  endfunction

  task automatic settle();
    repeat (6) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic strobe_hi(input logic [7:0] b);
    btn  = b;
    strb = 1'b1;
    settle();
  endtask

  task automatic strobe_lo();
    exp_c0 = model(btn, 1'b1);
    exp_c1 = model(btn, 1'b0);
    strb = 1'b0;
    n_strobes++;
    bits_read = 0;
    settle();
    chk("latched0", if0.latched, exp_c0);
    chk("latched1", if1.latched, exp_c1);
  endtask

  task automatic pulse_clk();
    jclk = 1'b1; settle();
    jclk = 1'b0; settle();
  endtask

  task automatic do_read(input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("bit0[%0d]", bits_read), {7'd0, if0.joy_data}, {7'd0, exp_bit(exp_c0, bits_read)});
      chk($sformatf("bit1[%0d]", bits_read), {7'd0, if1.joy_data}, {7'd0, exp_bit(exp_c1, bits_read)});
      pulse_clk();
      if (bits_read == 7) exp_done++;
      bits_read++;
    end
    chk("done_cnt0", 8'(done0), 8'(exp_done));
    chk("done_cnt1", 8'(done1), 8'(exp_done));
  endtask

  typedef struct {
    logic [7:0] b;
    logic [7:0] lat0;
    logic [7:0] lat1;
    int         nclk;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'h11, 8'h11, 8'h11, 12};
    vecs[1] = '{8'h30, 8'h00, 8'h30, 8};
    vecs[2] = '{8'hC0, 8'h00, 8'hC0, 8};
    vecs[3] = '{8'hF0, 8'h00, 8'hF0, 10};
    vecs[4] = '{8'h5A, 8'h5A, 8'h5A, 8};
    vecs[5] = '{8'hFF, 8'h0F, 8'hFF, 12};
    vecs[6] = '{8'h00, 8'h00, 8'h00, 8};
    vecs[7] = '{8'h8C, 8'h8C, 8'h8C, 5};

    // reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_data0", {7'd0, if0.joy_data}, 8'h01);
    chk("rst_lat0", if0.latched, 8'h00);
    chk("rst_done0", {7'd0, if0.read_done}, 8'h00);
    chk("rst_data1", {7'd0, if1.joy_data}, 8'h01);
    chk("rst_lat1", if1.latched, 8'h00);
    @(negedge clock);
    reset_n = 1'b1;
    settle();

`ifdef NES_JOYPAD_TURBO_EN
    // turbo A toggles every TP strobes, starting released
    begin
      logic [5:0] turbo_exp;
      turbo_exp = 6'b001100;
      ta = 1'b1;
      for (int k = 0; k < 6; k++) begin
        strobe_hi(8'h00);
        strobe_lo();
        chk($sformatf("turbo_a[%0d]", k), {7'd0, if0.latched[0]}, {7'd0, turbo_exp[k]});
        chk($sformatf("turbo_d[%0d]", k), {7'd0, if0.joy_data}, {7'd0, ~turbo_exp[k]});
      end
      ta = 1'b0;
    end
`endif

    // table-driven reads
    for (int v = 0; v < 8; v++) begin
      strobe_hi(vecs[v].b);
      strobe_lo();
      chk($sformatf("tbl_lat0[%0d]", v), if0.latched, vecs[v].lat0);
      chk($sformatf("tbl_lat1[%0d]", v), if1.latched, vecs[v].lat1);
      do_read(vecs[v].nclk);
    end

    // strobe re-asserted mid-read restarts with new buttons
    strobe_hi(8'h11); strobe_lo(); do_read(3);
    strobe_hi(8'h02); strobe_lo(); do_read(8);

    // clock edges while strobe high are ignored
    strobe_hi(8'h01);
    chk("hold_data0", {7'd0, if0.joy_data}, 8'h00);
    repeat (3) pulse_clk();
    chk("hold_data0b", {7'd0, if0.joy_data}, 8'h00);
    chk("hold_done", 8'(done0), 8'(exp_done));
    strobe_lo(); do_read(8);

    // clock edge in the same cycle as the strobe falling edge
    strobe_hi(8'h06);
    exp_c0 = model(btn, 1'b1);
    exp_c1 = model(btn, 1'b0);
    strb = 1'b0; jclk = 1'b1;
    n_strobes++;
    bits_read = 0;
    settle();
    chk("coinc_lat0", if0.latched, exp_c0);
    jclk = 1'b0;
    settle();
    do_read(8);

    // reset mid-read
    strobe_hi(8'h11); strobe_lo(); do_read(3);
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk("mrst_data0", {7'd0, if0.joy_data}, 8'h01);
    chk("mrst_lat0", if0.latched, 8'h00);
    chk("mrst_done0", {7'd0, if0.read_done}, 8'h00);
    chk("mrst_data1", {7'd0, if1.joy_data}, 8'h01);
    @(negedge clock);
    reset_n = 1'b1;
    n_strobes = 0;
    settle();
    strobe_hi(8'h81); strobe_lo(); do_read(9);

    // randomized: buttons change freely during SHIFT
    for (int r = 0; r < 25; r++) begin
      strobe_hi(8'($urandom));
      strobe_lo();
      btn = 8'($urandom);
      do_read(int'($urandom_range(0, 11)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
